pixel_axis_packer: RTL and testbench

Downstream stage of the Hawk/Owl camera controllers, sitting in `sys_clk` between the selected controller output and the S2MM AXI-Stream DMA port. It converts the camera pixel stream into 64-bit AXI-Stream beats:
- Owl: 48-bit words, 4×12-bit pixels.
- Hawk: 24-bit words, 2×12-bit pixels.

Each 12-bit pixel goes into a 16-bit lane. Beats are buffered in a small FIFO, and `tlast`/`tkeep` mark the end of the frame. The camera side has no backpressure, so overflow is detected, the beat is dropped and a flag is set.

---
 rtl/pixel_packer_pkg.sv | 34 +++
 rtl/pixel_packer_fifo.sv | 68 ++++++
 rtl/pixel_axis_packer.sv | 171 +++++++++++++++++
 tb/tb_pixel_axis_packer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_packer_pkg.sv
// Shared constants, beat type and pixel-to-lane helper for the pixel AXI-Stream packer.
// Define PIXEL_PACKER_MSB_ALIGN_EN to left-justify each pixel in its 16-bit lane.
package pixel_packer_pkg;

  localparam int PIX_W  = 12;
  localparam int LANE_W = 16;
  localparam int BEAT_W = 64;
  localparam int KEEP_W = BEAT_W / 8;

  localparam logic [KEEP_W-1:0] KEEP_FULL = 8'hFF;
  localparam logic [KEEP_W-1:0] KEEP_HALF = 8'h0F;
  localparam logic [KEEP_W-1:0] KEEP_NONE = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } packer_state_t;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  function automatic logic [LANE_W-1:0] pix_to_lane(input logic [PIX_W-1:0] pix);
`ifdef PIXEL_PACKER_MSB_ALIGN_EN
    return {pix, {(LANE_W-PIX_W){1'b0}}};
`else
    return {{(LANE_W-PIX_W){1'b0}}, pix};
`endif
  endfunction

endpackage

// File: rtl/pixel_packer_fifo.sv
// First-word-fall-through beat FIFO with synchronous flush; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module pixel_packer_fifo
  import pixel_packer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  flush_i,
  input  logic  push_i,
  input  beat_t din_i,
  input  logic  pop_i,
  output beat_t dout_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  beat_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;

  // Head is forced to zero while empty so the stream outputs idle at all-zero.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !rd_en) count_d = count_q + 1'b1;
      else if (!wr_en && rd_en) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/pixel_axis_packer.sv
// Packs Hawk (2x12-bit) or Owl (4x12-bit) pixel words into 64-bit AXI-Stream beats.
// Lane alignment is selected by PIXEL_PACKER_MSB_ALIGN_EN (see pixel_packer_pkg).
module pixel_axis_packer
  import pixel_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              frame_rst,
  input  logic              data_sel,
  input  logic [47:0]       data_in,
  input  logic              data_vld,
  input  logic              data_end,
  output logic [BEAT_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              overflow,
  output logic              busy
);

  packer_state_t       state_q, state_d;
  logic [BEAT_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic [2*LANE_W-1:0] half_q, half_d;
  logic                half_pend_q, half_pend_d;
  logic                sel_q, sel_d;
  logic                last_done_q, last_done_d;
  logic                overflow_q, overflow_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  beat_t               push_beat, fifo_head;
  logic                push, pop, can_push, fifo_full, fifo_empty;
  logic                beat_done;
  logic [BEAT_W-1:0]   new_beat, owl_beat;
  logic [2*LANE_W-1:0] hawk_lanes;

  assign owl_beat   = {pix_to_lane(data_in[47:36]), pix_to_lane(data_in[35:24]),
                       pix_to_lane(data_in[23:12]), pix_to_lane(data_in[11:0])};
  assign hawk_lanes = {pix_to_lane(data_in[23:12]), pix_to_lane(data_in[11:0])};

  assign pop      = m_axis_tvalid && m_axis_tready;
  assign can_push = !fifo_full || pop;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    half_d      = half_q;
    half_pend_d = half_pend_q;
    sel_d       = sel_q;
    last_done_d = last_done_q;
    overflow_d  = overflow_q;
    cnt_d       = cnt_q + CNT_W'(pop);
    push        = 1'b0;
    push_beat   = '0;
    beat_done   = 1'b0;
    new_beat    = '0;

    unique case (state_q)
      ACTIVE: begin
        if (data_vld) begin
          if (sel_q) begin
            beat_done = 1'b1;
            new_beat  = owl_beat;
          end else if (half_pend_q) begin
            beat_done   = 1'b1;
            new_beat    = {hawk_lanes, half_q};
            half_pend_d = 1'b0;
          end else begin
            half_d      = hawk_lanes;
            half_pend_d = 1'b1;
          end
        end
        // The previous beat is released only once its successor exists, so the
        // final beat can still be tagged tlast when data_end arrives.
        if (beat_done) begin
          push       = hold_vld_q;
          push_beat  = '{data: hold_q, keep: KEEP_FULL, last: 1'b0};
          hold_d     = new_beat;
          hold_vld_d = 1'b1;
        end
        if (data_end) state_d = DRAIN;
      end
      DRAIN: begin
        if (hold_vld_q) begin
          push        = 1'b1;
          push_beat   = '{data: hold_q, keep: KEEP_FULL, last: !half_pend_q};
          hold_vld_d  = 1'b0;
          last_done_d = !half_pend_q && can_push;
        end else if (half_pend_q) begin
          push        = 1'b1;
          push_beat   = '{data: {{(BEAT_W-2*LANE_W){1'b0}}, half_q}, keep: KEEP_HALF, last: 1'b1};
          half_pend_d = 1'b0;
          last_done_d = can_push;
        end else if (!last_done_q && can_push) begin
          // Empty terminator: frame had no data, or its tlast beat was dropped.
          push        = 1'b1;
          push_beat   = '{data: '0, keep: KEEP_NONE, last: 1'b1};
          last_done_d = 1'b1;
        end
        if (pop && fifo_head.last) state_d = IDLE;
      end
      default: ;
    endcase

    if (push && !can_push) overflow_d = 1'b1;

    if (frame_rst) begin
      state_d     = ACTIVE;
      hold_vld_d  = 1'b0;
      half_pend_d = 1'b0;
      last_done_d = 1'b0;
      overflow_d  = 1'b0;
      cnt_d       = '0;
      sel_d       = data_sel;
      push        = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      half_q      <= '0;
      half_pend_q <= 1'b0;
      sel_q       <= 1'b0;
      last_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      half_q      <= half_d;
      half_pend_q <= half_pend_d;
      sel_q       <= sel_d;
      last_done_q <= last_done_d;
      overflow_q  <= overflow_d;
      cnt_q       <= cnt_d;
    end
  end

  pixel_packer_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .flush_i (frame_rst),
    .push_i  (push),
    .din_i   (push_beat),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_head.data;
  assign m_axis_tkeep  = fifo_head.keep;
  assign m_axis_tlast  = fifo_head.last;
  assign xfer_cnt      = cnt_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_axis_packer.sv
// Randomized self-checking bench for pixel_axis_packer; expected beats come from a
// frame-level model (words -> beat list) compared against a stream monitor.
module tb_pixel_axis_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_rst = 1'b0;
  logic        data_sel = 1'b0;
  logic [47:0] data_in = '0;
  logic        data_vld = 1'b0;
  logic        data_end = 1'b0;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready = 1'b0;
  logic [31:0] xfer_cnt;
  logic        overflow;
  logic        busy;

  always #5 clk = ~clk;

  pixel_axis_packer #(
    .FIFO_DEPTH(16),
    .CNT_W(32)
  ) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .frame_rst     (frame_rst),
    .data_sel      (data_sel),
    .data_in       (data_in),
    .data_vld      (data_vld),
    .data_end      (data_end),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .xfer_cnt      (xfer_cnt),
    .overflow      (overflow),
    .busy          (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  logic [47:0] words [$];
  logic [72:0] obs_q [$];
  logic [72:0] exp_q [$];
  int          rdy_mode = 0;

  // tready policy: 0 = stalled, 1 = always ready, 2 = random ~70%.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  int   cyc = 0;
  int   tlast_cyc = -1;
  int   busy_fall_cyc = -1;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tvalid && tready) begin
      obs_q.push_back({tdata, tkeep, tlast});
      if (tlast) tlast_cyc = cyc;
    end
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  function automatic logic [15:0] lane(input logic [11:0] p);
`ifdef PIXEL_PACKER_MSB_ALIGN_EN
    return {p, 4'h0};
`else
    return {4'h0, p};
`endif
  endfunction

  function automatic logic [63:0] owl_data(input logic [47:0] w);
    return {lane(w[47:36]), lane(w[35:24]), lane(w[23:12]), lane(w[11:0])};
  endfunction

  // Frame-level reference: beats formed from the word list, tlast on the final one.
  task automatic build_expected(input bit owl);
    int n;
    n = words.size();
    exp_q.delete();
    if (n == 0) begin
      exp_q.push_back({64'h0, 8'h00, 1'b1});
    end else if (owl) begin
      for (int i = 0; i < n; i++)
        exp_q.push_back({owl_data(words[i]), 8'hFF, (i == n - 1)});
    end else begin
      for (int i = 0; i + 1 < n; i += 2)
        exp_q.push_back({lane(words[i+1][23:12]), lane(words[i+1][11:0]),
                         lane(words[i][23:12]), lane(words[i][11:0]), 8'hFF, (i + 2 == n)});
      if (n % 2 == 1)
        exp_q.push_back({32'h0, lane(words[n-1][23:12]), lane(words[n-1][11:0]), 8'h0F, 1'b1});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame_rst(input logic sel);
    frame_rst = 1'b1;
    data_sel  = sel;
    tick();
    frame_rst = 1'b0;
  endtask

  task automatic send_word(input logic [47:0] w, input logic with_end);
    data_in  = w;
    data_vld = 1'b1;
    data_end = with_end;
    tick();
    data_vld = 1'b0;
    data_end = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle"}, busy, 1'b0);
    tick();
  endtask

  task automatic compare_beats(input string tag);
    int n;
    check({tag, "_nbeats"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic run_frame(input string tag, input bit owl, input bit end_alone,
                           input int rmode, input int maxgap);
    int n;
    n = words.size();
    obs_q.delete();
    rdy_mode = rmode;
    pulse_frame_rst(owl);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) tick();
      send_word(words[i], !end_alone && (i == n - 1));
    end
    if (end_alone || n == 0) begin
      data_end = 1'b1;
      tick();
      data_end = 1'b0;
    end
    wait_idle(tag);
    build_expected(owl);
    compare_beats(tag);
    check({tag, "_cnt"}, xfer_cnt, exp_q.size());
    check({tag, "_ovf"}, overflow, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 64'h0);
    check("rst_tkeep", tkeep, 8'h00);
    check("rst_tlast", tlast, 1'b0);
    check("rst_cnt", xfer_cnt, 32'h0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Owl, end coincident with third word, tready high
    words = '{48'hABC_BCA_CAB_ABC, 48'h0AB_C0A_BC0_ABC, 48'hFFF_ABC_000_ABC};
    run_frame("owl", 1'b1, 1'b0, 1, 0);
    check("owl_busy_fall", busy_fall_cyc, tlast_cyc + 1);

    // Hawk odd count, end alone, random garbage in unused upper bits
    words = '{48'h5A5222111, 48'hA5A444333, 48'h777666555};
    run_frame("hawk_odd", 1'b0, 1'b1, 1, 0);

    // Empty frame
    words.delete();
    run_frame("empty", 1'b1, 1'b1, 1, 0);

    // Back-to-back Owl throughput
    words.delete();
    for (int i = 0; i < 15; i++) words.push_back({$urandom, $urandom});
    run_frame("owl_b2b", 1'b1, 1'b0, 1, 0);

    // Backpressure overflow: 20 words into a stalled 16-deep FIFO
    words.delete();
    for (int i = 0; i < 20; i++) words.push_back({$urandom, $urandom});
    obs_q.delete();
    rdy_mode = 0;
    pulse_frame_rst(1'b1);
    for (int i = 0; i < 20; i++) send_word(words[i], i == 19);
    repeat (4) tick();
    check("bp_ovf_set", overflow, 1'b1);
    check("bp_busy", busy, 1'b1);
    rdy_mode = 1;
    wait_idle("bp");
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({owl_data(words[i]), 8'hFF, 1'b0});
    exp_q.push_back({64'h0, 8'h00, 1'b1});
    compare_beats("bp");
    check("bp_cnt", xfer_cnt, 17);
    check("bp_ovf_hold", overflow, 1'b1);

    // frame_rst mid-frame with stale beats queued
    obs_q.delete();
    rdy_mode = 0;
    pulse_frame_rst(1'b1);
    for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, 1'b0);
    words.delete();
    for (int i = 0; i < 2; i++) words.push_back({$urandom, $urandom});
    run_frame("midrst", 1'b1, 1'b0, 1, 0);

    // Randomized frames, random mode / length / gaps / backpressure
    for (int f = 0; f < 8; f++) begin
      bit owl;
      owl = $urandom_range(0, 1);
      words.delete();
      for (int i = 0, n = $urandom_range(0, owl ? 15 : 30); i < n; i++)
        words.push_back({$urandom, $urandom});
      run_frame($sformatf("rnd%0d", f), owl, $urandom_range(0, 1), 2, 2);
    end

    // Asynchronous reset in DRAIN, between clock edges
    rdy_mode = 0;
    pulse_frame_rst(1'b1);
    for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, i == 2);
    repeat (2) tick();
    check("ar_pre_busy", busy, 1'b1);
    check("ar_pre_tvalid", tvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_tvalid", tvalid, 1'b0);
    check("ar_tdata", tdata, 64'h0);
    check("ar_tkeep", tkeep, 8'h00);
    check("ar_tlast", tlast, 1'b0);
    check("ar_cnt", xfer_cnt, 32'h0);
    check("ar_ovf", overflow, 1'b0);
    check("ar_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    rdy_mode = 1;
    tick();
    for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, i == 3);
    repeat (3) tick();
    check("ar_ign_tvalid", tvalid, 1'b0);
    check("ar_ign_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
